pe_mac_pipe: RTL and testbench
==============================

Name: pe_mac_pipe

Overview:
Parametrised successor of the single-lane chained PE: a LANES-wide dot-product processing element with a 2-stage pipeline, valid tagging and runtime mode select.
Modes: chained MAC, max-pool, local accumulation over a programmable window, and bypass.
Optional saturating arithmetic.
Sits in the systolic array; psum_out feeds the psum_in of the next PE.

Parameters:
WEIGHT_WIDTH, 8, signed weight width per lane
IFM_WIDTH, 8, signed ifm width per lane
PSUM_WIDTH, 16, signed partial-sum width
LANES, 4, parallel multiply lanes reduced per beat (>=1)
ACC_LEN_W, 8, width of accumulation window length
SATURATE, 1, 1 = clamp results to PSUM range; 0 = two's-complement wrap

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
clear  in  1  synchronous flush of pipeline and accumulator
mode  in  2  0=MAC, 1=MAX, 2=LACC, 3=BYP; sampled with each beat
acc_len  in  ACC_LEN_W  LACC window length in beats; 0 treated as 1
in_valid  in  1  beat present on ifm/wgt/psum_in
ifm  in  LANES*IFM_WIDTH  packed signed ifm, lane 0 in LSBs
wgt  in  LANES*WEIGHT_WIDTH  packed signed weights, lane 0 in LSBs
psum_in  in  PSUM_WIDTH  signed upstream partial sum / LACC bias
out_valid  out  1  one-cycle pulse; psum_out is new this cycle
psum_out  out  PSUM_WIDTH  signed result; holds last value when out_valid=0
busy  out  1  beat in flight or LACC window open

Behaviour:
- Reset: asynchronous on rst high. All pipeline registers, accumulator and beat counter go to 0. out_valid=0, psum_out=0, busy=0. Takes effect immediately, including mid-pipeline and mid-window.
- No backpressure. One beat accepted per cycle when in_valid=1. Fully pipelined.
- Stage 1 (registered on in_valid): per-lane signed products (IFM_WIDTH+WEIGHT_WIDTH bits); per-lane sign-extended ifm; psum_in; mode; valid bit.
- Stage 2: dot = sum of lane products at full width (IFM_WIDTH+WEIGHT_WIDTH+clog2(LANES)+1 bits); combine per mode; saturate or wrap to PSUM_WIDTH; register into psum_out/out_valid.
- Latency: in_valid in cycle N gives out_valid in cycle N+2 for MAC, MAX and BYP.
- MAC: psum_out = fit(psum_in + dot).
- MAX: psum_out = max(psum_in, max over lanes of ifm), signed compare. wgt is ignored. Never saturates.
- BYP: psum_out = psum_in.
- LACC, beat counter states:
  - IDLE (count=0): a beat opens a window. Latch len = max(acc_len,1); acc = fit(psum_in + dot).
  - OPEN: each beat does acc = fit(acc + dot). psum_in is ignored after the first beat.
  - On the len-th beat, the stage-2 result goes to psum_out with an out_valid pulse, in the same N+2 timing as that final beat. Counter returns to IDLE.
  - The next window may start on the very next cycle.
  - No out_valid on non-final beats.
  - len=1 behaves exactly like MAC.
- Mode change while a LACC window is OPEN aborts the window: acc and count are zeroed, the window emits no output, and the new beat is processed in its own mode. acc_len changes mid-window are ignored.
- fit(): if SATURATE=1, clamp to [-2^(PSUM_WIDTH-1), 2^(PSUM_WIDTH-1)-1]. A clamped acc continues from the clamped value. If SATURATE=0, keep the low PSUM_WIDTH bits.
- clear (synchronous, priority over in_valid):
  - drops both pipeline valid bits, so in-flight beats produce no out_valid;
  - zeroes acc and count;
  - drops any beat presented the same cycle;
  - leaves psum_out unchanged.
- busy = stage1 valid | stage2 valid | (count != 0).

Test Plan:
- MAC, LANES=4: ifm {1,2,3,4}, wgt {1,1,1,1}, psum_in=5, in_valid at cycle N -> out_valid at N+2, psum_out=15. Back-to-back beats give back-to-back outputs.
- Saturation: ifm all 127, wgt all 127, psum_in=32767 -> 32767. ifm all -128, wgt all 127, psum_in=-32768 -> -32768. Same first case with SATURATE=0 -> 31747.
- MAX: ifm {-5,7,3,-128}, psum_in=10 -> 10; psum_in=-20 -> 7. wgt random, no effect.
- LACC, acc_len=3: three beats with dot=2,3,4, first psum_in=100 -> exactly one out_valid, 2 cycles after beat 3, psum_out=109. An immediate second window with acc_len=0 behaves as MAC.
- Abort/clear: LACC acc_len=4, 2 beats, then a MAC beat (ifm {1,1,1,1}, wgt {2,2,2,2}, psum_in=0) -> only the MAC output 8 appears. clear during an open window with a beat in flight -> no out_valid, busy=0 next cycle, psum_out unchanged.
- Reset mid-operation: rst high with 2 beats in flight and a window open -> out_valid=0, psum_out=0, busy=0 immediately. After release, a fresh MAC beat yields the correct result at N+2.

Source files
------------

// File: rtl/pe_mac_pipe.sv
// LANES-wide dot-product PE with a two-stage pipeline for the systolic array.
// Modes: chained MAC, max-pool, windowed local accumulation (LACC) and bypass.
module pe_mac_pipe #(
    parameter int WEIGHT_WIDTH = 8,
    parameter int IFM_WIDTH    = 8,
    parameter int PSUM_WIDTH   = 16,
    parameter int LANES        = 4,
    parameter int ACC_LEN_W    = 8,
    parameter int SATURATE     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic [1:0]                    mode,
    input  logic [ACC_LEN_W-1:0]          acc_len,
    input  logic                          in_valid,
    input  logic [LANES*IFM_WIDTH-1:0]    ifm,
    input  logic [LANES*WEIGHT_WIDTH-1:0] wgt,
    input  logic [PSUM_WIDTH-1:0]         psum_in,
    output logic                          out_valid,
    output logic [PSUM_WIDTH-1:0]         psum_out,
    output logic                          busy
);

    localparam int PROD_W = IFM_WIDTH + WEIGHT_WIDTH;
    localparam int DOT_W  = PROD_W + $clog2(LANES) + 1;
    localparam int SUM_W  = ((PSUM_WIDTH > DOT_W) ? PSUM_WIDTH : DOT_W) + 1;
    localparam bit SAT_EN = (SATURATE != 0);
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'sd1 <<< (PSUM_WIDTH - 1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(64'sd1 <<< (PSUM_WIDTH - 1)));

    localparam logic [1:0] MODE_MAC  = 2'd0;
    localparam logic [1:0] MODE_MAX  = 2'd1;
    localparam logic [1:0] MODE_LACC = 2'd2;
    localparam logic [1:0] MODE_BYP  = 2'd3;

    function automatic logic signed [PSUM_WIDTH-1:0] fit(input logic signed [SUM_W-1:0] x);
        logic signed [PSUM_WIDTH-1:0] r;
        if (SAT_EN && (x > SAT_MAX)) begin
            r = SAT_MAX[PSUM_WIDTH-1:0];
        end else if (SAT_EN && (x < SAT_MIN)) begin
            r = SAT_MIN[PSUM_WIDTH-1:0];
        end else begin
            r = x[PSUM_WIDTH-1:0];
        end
        return r;
    endfunction

    logic signed [PROD_W-1:0]     prod_d  [LANES];
    logic signed [PROD_W-1:0]     prod_q  [LANES];
    logic signed [PSUM_WIDTH-1:0] ifm_d   [LANES];
    logic signed [PSUM_WIDTH-1:0] ifm_q   [LANES];
    logic signed [PSUM_WIDTH-1:0] psum_q;
    logic [1:0]                   mode_q;
    logic                         v1_q, v2_q, first_q, last_q, first_d, last_d;
    logic [ACC_LEN_W-1:0]         count_q, count_d, len_q, len_d, len_eff_s;
    logic signed [PSUM_WIDTH-1:0] acc_q, acc_d, res_d, max_s;
    logic signed [SUM_W-1:0]      dot_s, base_s;
    logic                         emit_s, out_valid_q;
    logic [PSUM_WIDTH-1:0]        psum_out_q;

    // Per-lane products and sign-extended ifm for stage 1
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            prod_d[l] = PROD_W'($signed(ifm[l*IFM_WIDTH +: IFM_WIDTH]))
                      * PROD_W'($signed(wgt[l*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
            ifm_d[l]  = PSUM_WIDTH'($signed(ifm[l*IFM_WIDTH +: IFM_WIDTH]));
        end
    end

    // LACC beat counter: tags each accepted beat as window-first / window-last
    always_comb begin
        len_eff_s = (acc_len == '0) ? ACC_LEN_W'(1'b1) : acc_len;
        count_d   = count_q;
        len_d     = len_q;
        first_d   = 1'b0;
        last_d    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (in_valid) begin
            if (mode == MODE_LACC) begin
                if (count_q == '0) begin
                    first_d = 1'b1;
                    len_d   = len_eff_s;
                    if (len_eff_s == ACC_LEN_W'(1'b1)) begin
                        last_d  = 1'b1;
                        count_d = '0;
                    end else begin
                        count_d = ACC_LEN_W'(1'b1);
                    end
                end else if ((count_q + ACC_LEN_W'(1'b1)) == len_q) begin
                    last_d  = 1'b1;
                    count_d = '0;
                end else begin
                    count_d = count_q + ACC_LEN_W'(1'b1);
                end
            end else begin
                // any other mode aborts an open window
                count_d = '0;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Stage 1 registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < LANES; l++) begin
                prod_q[l] <= '0;
                ifm_q[l]  <= '0;
            end
            psum_q  <= '0;
            mode_q  <= 2'd0;
            v1_q    <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            v1_q    <= in_valid & ~clear;
            count_q <= count_d;
            len_q   <= len_d;
            if (in_valid && !clear) begin
                for (int l = 0; l < LANES; l++) begin
                    prod_q[l] <= prod_d[l];
                    ifm_q[l]  <= ifm_d[l];
                end
                psum_q  <= psum_in;
                mode_q  <= mode;
                first_q <= first_d;
                last_q  <= last_d;
            end
        end
    end

    // Stage 2: reduction and per-mode combine
    always_comb begin
        dot_s = '0;
        for (int l = 0; l < LANES; l++) begin
            dot_s = dot_s + SUM_W'(prod_q[l]);
        end
        max_s = psum_q;
        for (int l = 0; l < LANES; l++) begin
            if (ifm_q[l] > max_s) begin
                max_s = ifm_q[l];
            end else begin
                max_s = max_s;
            end
        end
        base_s = first_q ? SUM_W'(psum_q) : SUM_W'(acc_q);
        res_d  = psum_q;
        emit_s = 1'b0;
        acc_d  = acc_q;
        if (v1_q) begin
            case (mode_q)
                MODE_MAC: begin
                    res_d  = fit(SUM_W'(psum_q) + dot_s);
                    emit_s = 1'b1;
                    acc_d  = '0;
                end
                MODE_MAX: begin
                    res_d  = max_s;
                    emit_s = 1'b1;
                    acc_d  = '0;
                end
                MODE_LACC: begin
                    res_d  = fit(base_s + dot_s);
                    emit_s = last_q;
                    acc_d  = last_q ? '0 : res_d;
                end
                MODE_BYP: begin
                    res_d  = psum_q;
                    emit_s = 1'b1;
                    acc_d  = '0;
                end
                default: begin
                    res_d  = psum_q;
                    emit_s = 1'b0;
                    acc_d  = '0;
                end
            endcase
        end else begin
            acc_d = acc_q;
        end
    end

    // Stage 2 registers; clear keeps psum_out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            psum_out_q  <= '0;
            acc_q       <= '0;
        end else if (clear) begin
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
        end else begin
            v2_q        <= v1_q;
            out_valid_q <= v1_q & emit_s;
            acc_q       <= acc_d;
            if (v1_q && emit_s) begin
                psum_out_q <= res_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign psum_out  = psum_out_q;
    assign busy      = v1_q | v2_q | (count_q != '0);

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Directed bench for pe_mac_pipe; a saturating and a wrapping instance share stimulus.
module tb_pe_mac_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, clear, in_valid;
    logic [1:0]         mode;
    logic [7:0]         acc_len;
    logic [31:0]        ifm, wgt;
    logic signed [15:0] psum_in;
    logic               out_valid, busy, out_valid_w, busy_w;
    logic signed [15:0] psum_out, psum_out_w;
    logic signed [15:0] held;

    int tests_run = 0;
    int fails = 0;

    pe_mac_pipe #(.WEIGHT_WIDTH(8), .IFM_WIDTH(8), .PSUM_WIDTH(16), .LANES(4),
                  .ACC_LEN_W(8), .SATURATE(1)) dut (
        .clk(clk), .rst(rst), .clear(clear), .mode(mode), .acc_len(acc_len),
        .in_valid(in_valid), .ifm(ifm), .wgt(wgt), .psum_in(psum_in),
        .out_valid(out_valid), .psum_out(psum_out), .busy(busy));

    pe_mac_pipe #(.WEIGHT_WIDTH(8), .IFM_WIDTH(8), .PSUM_WIDTH(16), .LANES(4),
                  .ACC_LEN_W(8), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .clear(clear), .mode(mode), .acc_len(acc_len),
        .in_valid(in_valid), .ifm(ifm), .wgt(wgt), .psum_in(psum_in),
        .out_valid(out_valid_w), .psum_out(psum_out_w), .busy(busy_w));

    task automatic drive(input logic [1:0] m, input logic [7:0] len, input logic [31:0] f,
                         input logic [31:0] w, input logic signed [15:0] p);
        mode = m; acc_len = len; ifm = f; wgt = w; psum_in = p; in_valid = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; mode = 2'd0; acc_len = 8'd0;
        ifm = 32'h0; wgt = 32'h0; psum_in = 16'sd0;
        step(); step();
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        tests_run++; if (psum_out !== 16'sd0) begin fails++; $display("FAIL reset_psum: got %0d want 0", psum_out); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_mac();
        drive(2'd0, 8'd0, 32'h04030201, 32'h01010101, 16'sd5);
        step(); idle();
        tests_run++; if (out_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL mac_n1: got valid=%0b busy=%0b want 0/1", out_valid, busy); end
        step();
        tests_run++; if (out_valid !== 1'b1 || psum_out !== 16'sd15) begin fails++; $display("FAIL mac_n2: got valid=%0b psum=%0d want 1/15", out_valid, psum_out); end
        step();
        tests_run++; if (out_valid !== 1'b0 || psum_out !== 16'sd15) begin fails++; $display("FAIL mac_hold: got valid=%0b psum=%0d want 0/15", out_valid, psum_out); end
    endtask

    task automatic test_back_to_back();
        drive(2'd0, 8'd0, 32'h04030201, 32'h01010101, 16'sd0);
        step();
        drive(2'd0, 8'd0, 32'h02020202, 32'h03030303, -16'sd100);
        step();
        drive(2'd0, 8'd0, 32'hFCFDFEFF, 32'h02020202, 16'sd7);
        tests_run++; if (out_valid !== 1'b1 || psum_out !== 16'sd10) begin fails++; $display("FAIL b2b_0: got valid=%0b psum=%0d want 1/10", out_valid, psum_out); end
        step(); idle();
        tests_run++; if (out_valid !== 1'b1 || psum_out !== -16'sd76) begin fails++; $display("FAIL b2b_1: got valid=%0b psum=%0d want 1/-76", out_valid, psum_out); end
        step();
        tests_run++; if (out_valid !== 1'b1 || psum_out !== -16'sd13) begin fails++; $display("FAIL b2b_2: got valid=%0b psum=%0d want 1/-13", out_valid, psum_out); end
        step();
        tests_run++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL b2b_end: got valid=%0b busy=%0b want 0/0", out_valid, busy); end
    endtask

    task automatic test_saturate();
        drive(2'd0, 8'd0, 32'h7F7F7F7F, 32'h7F7F7F7F, 16'sh7FFF);
        step();
        drive(2'd0, 8'd0, 32'h80808080, 32'h7F7F7F7F, 16'sh8000);
        step(); idle();
        tests_run++; if (psum_out !== 16'sh7FFF) begin fails++; $display("FAIL sat_pos: got %0d want 32767", psum_out); end
        tests_run++; if (psum_out_w !== 16'sd31747) begin fails++; $display("FAIL wrap_pos: got %0d want 31747", psum_out_w); end
        step();
        tests_run++; if (psum_out !== 16'sh8000) begin fails++; $display("FAIL sat_neg: got %0d want -32768", psum_out); end
        tests_run++; if (psum_out_w !== 16'sh8200) begin fails++; $display("FAIL wrap_neg: got %0d want -32256", psum_out_w); end
        step();
    endtask

    task automatic test_max();
        drive(2'd1, 8'd0, 32'h800307FB, $urandom, 16'sd10);
        step();
        drive(2'd1, 8'd0, 32'h800307FB, $urandom, -16'sd20);
        step(); idle();
        tests_run++; if (out_valid !== 1'b1 || psum_out !== 16'sd10) begin fails++; $display("FAIL max_psum: got valid=%0b psum=%0d want 1/10", out_valid, psum_out); end
        step();
        tests_run++; if (out_valid !== 1'b1 || psum_out !== 16'sd7) begin fails++; $display("FAIL max_lane: got valid=%0b psum=%0d want 1/7", out_valid, psum_out); end
        drive(2'd3, 8'd0, 32'h7F7F7F7F, 32'h7F7F7F7F, -16'sd1234);
        step(); idle(); step();
        tests_run++; if (out_valid !== 1'b1 || psum_out !== -16'sd1234) begin fails++; $display("FAIL byp: got valid=%0b psum=%0d want 1/-1234", out_valid, psum_out); end
        step();
    endtask

    task automatic test_lacc();
        drive(2'd2, 8'd3, 32'h00000002, 32'h01010101, 16'sd100);
        step();
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lacc_c1: got valid=%0b want 0", out_valid); end
        drive(2'd2, 8'd7, 32'h00000003, 32'h01010101, 16'sd555);
        step();
        tests_run++; if (out_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL lacc_c2: got valid=%0b busy=%0b want 0/1", out_valid, busy); end
        drive(2'd2, 8'd7, 32'h00000004, 32'h01010101, 16'sd555);
        step();
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lacc_c3: got valid=%0b want 0", out_valid); end
        drive(2'd2, 8'd0, 32'h04030201, 32'h01010101, 16'sd5);
        step(); idle();
        tests_run++; if (out_valid !== 1'b1 || psum_out !== 16'sd109) begin fails++; $display("FAIL lacc_win: got valid=%0b psum=%0d want 1/109", out_valid, psum_out); end
        step();
        tests_run++; if (out_valid !== 1'b1 || psum_out !== 16'sd15) begin fails++; $display("FAIL lacc_len0: got valid=%0b psum=%0d want 1/15", out_valid, psum_out); end
        step();
        tests_run++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL lacc_end: got valid=%0b busy=%0b want 0/0", out_valid, busy); end
    endtask

    task automatic test_abort();
        drive(2'd2, 8'd4, 32'h00000005, 32'h01010101, 16'sd50);
        step();
        drive(2'd2, 8'd4, 32'h00000005, 32'h01010101, 16'sd50);
        step();
        drive(2'd0, 8'd4, 32'h01010101, 32'h02020202, 16'sd0);
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL abort_c2: got valid=%0b want 0", out_valid); end
        step(); idle();
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL abort_c3: got valid=%0b want 0", out_valid); end
        step();
        tests_run++; if (out_valid !== 1'b1 || psum_out !== 16'sd8) begin fails++; $display("FAIL abort_mac: got valid=%0b psum=%0d want 1/8", out_valid, psum_out); end
        step();
        tests_run++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL abort_idle: got valid=%0b busy=%0b want 0/0", out_valid, busy); end
        drive(2'd2, 8'd2, 32'h00000001, 32'h01010101, 16'sd3);
        step();
        drive(2'd2, 8'd2, 32'h00000001, 32'h01010101, 16'sd99);
        step(); idle(); step();
        tests_run++; if (out_valid !== 1'b1 || psum_out !== 16'sd5) begin fails++; $display("FAIL abort_next: got valid=%0b psum=%0d want 1/5", out_valid, psum_out); end
        step();
    endtask

    task automatic test_clear();
        held = psum_out;
        drive(2'd2, 8'd4, 32'h00000005, 32'h01010101, 16'sd50);
        step();
        drive(2'd2, 8'd4, 32'h00000005, 32'h01010101, 16'sd50);
        step();
        drive(2'd0, 8'd0, 32'h01010101, 32'h01010101, 16'sd77);
        clear = 1'b1;
        step(); clear = 1'b0; idle();
        tests_run++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL clear_now: got valid=%0b busy=%0b want 0/0", out_valid, busy); end
        tests_run++; if (psum_out !== held) begin fails++; $display("FAIL clear_hold: got %0d want %0d", psum_out, held); end
        step();
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clear_drop: got valid=%0b want 0", out_valid); end
        drive(2'd2, 8'd2, 32'h00000001, 32'h01010101, 16'sd10);
        step();
        drive(2'd2, 8'd2, 32'h00000002, 32'h01010101, 16'sd0);
        step(); idle(); step();
        tests_run++; if (out_valid !== 1'b1 || psum_out !== 16'sd13) begin fails++; $display("FAIL clear_next: got valid=%0b psum=%0d want 1/13", out_valid, psum_out); end
        step();
    endtask

    task automatic test_reset_mid();
        drive(2'd2, 8'd4, 32'h00000005, 32'h01010101, 16'sd50);
        step();
        drive(2'd2, 8'd4, 32'h00000005, 32'h01010101, 16'sd50);
        step(); idle();
        rst = 1'b1;
        #1;
        tests_run++; if (out_valid !== 1'b0 || psum_out !== 16'sd0 || busy !== 1'b0) begin fails++; $display("FAIL rst_mid: got valid=%0b psum=%0d busy=%0b want 0/0/0", out_valid, psum_out, busy); end
        step();
        rst = 1'b0;
        step();
        drive(2'd0, 8'd0, 32'h04030201, 32'h02020202, -16'sd3);
        step(); idle();
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_after_n1: got valid=%0b want 0", out_valid); end
        step();
        tests_run++; if (out_valid !== 1'b1 || psum_out !== 16'sd17) begin fails++; $display("FAIL rst_after_n2: got valid=%0b psum=%0d want 1/17", out_valid, psum_out); end
        step();
    endtask

    initial begin
        test_reset();
        test_mac();
        test_back_to_back();
        test_saturate();
        test_max();
        test_lacc();
        test_abort();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
